// File: rtl/syscall_pkg.sv
// Shared service codes, FSM states and ASCII constants for the syscall unit.
package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h61;
    localparam logic [7:0] ASCII_MINUS = 8'h2d;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_BCD,
        S_FETCH,
        S_WAIT,
        S_STR_EMIT,
        S_CHAR,
        S_INT_EMIT,
        S_DONE
    } state_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        if (d < 4'd10)
            return ASCII_0 + {4'd0, d};
        return ASCII_A + {4'd0, d} - 8'd10;
    endfunction

endpackage

// File: rtl/syscall_unit_bin2bcd_seq.sv
// 32-bit sequential double-dabble converter: one bit per cycle, 32 cycles.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd
);

    logic [31:0] bin_q;
    logic [39:0] bcd_q;
    logic [39:0] adj;
    logic [4:0]  cnt_q;
    logic        busy_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            {bcd_q, bin_q} <= {adj[38:0], bin_q, 1'b0};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31)
                busy_q <= 1'b0;
        end
    end

    // done flags the cycle whose closing edge completes the last shift
    assign busy = busy_q;
    assign done = busy_q && (cnt_q == 5'd31);
    assign bcd  = bcd_q;

endmodule

// File: rtl/syscall_unit.sv
// MIPS syscall service unit: print_int/string/char, exit; stalls the pipe.
// Define SYSCALL_HEX_EN to enable print_hex (code 34).
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int MAX_STR_LEN = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall,
    input  logic [31:0]       sys_call_reg,
    input  logic [31:0]       std_out_address,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [31:0]       code_q, code_d;
    logic [31:0]       arg_q, arg_d;
    logic [3:0]        idx_q, idx_d;
    logic              started_q, started_d;
    logic              hex_q, hex_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;
    logic              halted_q, halted_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;

    logic              accept;
    logic              bcd_start;
    logic              bcd_busy;
    logic              bcd_done;
    logic [39:0]       bcd;
    logic [31:0]       mag;
    logic [3:0]        nib;
    logic [7:0]        str_byte;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bcd_start),
        .bin   (mag),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    assign mag      = arg_q[31] ? (~arg_q + 32'd1) : arg_q;
    assign nib      = hex_q ? arg_q[{idx_q[2:0], 2'b00} +: 4]
                            : bcd[{idx_q, 2'b00} +: 4];
    assign str_byte = word_q[{~ptr_q[1:0], 3'b000} +: 8];
    assign accept   = rst_n && syscall && (state_q == S_IDLE) && !halted_q;
    assign stall    = accept || (state_q != S_IDLE);
    assign halted   = halted_q;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        arg_d     = arg_q;
        idx_d     = idx_q;
        started_d = started_q;
        hex_d     = hex_q;
        sign_d    = sign_q;
        err_d     = err_q;
        halted_d  = halted_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        out_valid = 1'b0;
        out_data  = '0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        done      = 1'b0;
        err       = 1'b0;
        bcd_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    code_d  = sys_call_reg;
                    arg_d   = std_out_address;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                err_d     = 1'b0;
                started_d = 1'b0;
                hex_d     = 1'b0;
                unique case (1'b1)
                    code_q == SYS_PRINT_INT: begin
                        bcd_start = 1'b1;
                        sign_d    = arg_q[31];
                        idx_d     = 4'd9;
                        state_d   = S_BCD;
                    end
                    code_q == SYS_PRINT_STR: begin
                        ptr_d   = ADDR_W'(arg_q);
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                    code_q == SYS_EXIT: begin
                        halted_d = 1'b1;
                        state_d  = S_DONE;
                    end
                    code_q == SYS_PRINT_CHAR: state_d = S_CHAR;
`ifdef SYSCALL_HEX_EN
                    code_q == SYS_PRINT_HEX: begin
                        hex_d     = 1'b1;
                        started_d = 1'b1;
                        idx_d     = 4'd7;
                        state_d   = S_INT_EMIT;
                    end
`endif
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_BCD: begin
                // sign byte goes out while the converter runs
                out_valid = sign_q;
                out_data  = sign_q ? ASCII_MINUS : 8'h00;
                if (sign_q && out_ready)
                    sign_d = 1'b0;
                if ((bcd_done || !bcd_busy) && !sign_d)
                    state_d = S_INT_EMIT;
            end
            S_INT_EMIT: begin
                // leading zero digits are skipped one per cycle
                out_valid = started_q || (nib != 4'd0) || (idx_q == 4'd0);
                out_data  = out_valid ? digit_ascii(nib) : 8'h00;
                if (out_valid && out_ready) begin
                    started_d = 1'b1;
                    if (idx_q == 4'd0)
                        state_d = S_DONE;
                    else
                        idx_d = idx_q - 4'd1;
                end else if (!out_valid) begin
                    idx_d = idx_q - 4'd1;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = {ptr_q[ADDR_W-1:2], 2'b00};
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                word_d  = mem_rd_data;
                state_d = S_STR_EMIT;
            end
            S_STR_EMIT: begin
                if (str_byte == 8'h00) begin
                    state_d = S_DONE;
                end else begin
                    out_valid = 1'b1;
                    out_data  = str_byte;
                    if (out_ready) begin
                        ptr_d = ptr_q + 1'b1;
                        cnt_d = cnt_q + 32'd1;
                        if (cnt_q == 32'(MAX_STR_LEN - 1))
                            state_d = S_DONE;
                        else if (ptr_q[1:0] == 2'b11)
                            state_d = S_FETCH;
                    end
                end
            end
            S_CHAR: begin
                out_valid = 1'b1;
                out_data  = arg_q[7:0];
                if (out_ready)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            arg_q     <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
            hex_q     <= 1'b0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            halted_q  <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            arg_q     <= arg_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            hex_q     <= hex_d;
            sign_q    <= sign_d;
            err_q     <= err_d;
            halted_q  <= halted_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: vector table, hand sequences,
// and randomized calls against a string-level reference model.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall = 1'b0;
    logic [31:0] sys_call_reg = '0;
    logic [31:0] std_out_address = '0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data = '0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic        stall, done, err, halted;

    logic        syscall2 = 1'b0;
    logic [31:0] code2 = '0;
    logic [31:0] arg2 = '0;
    logic        mem_rd_en2;
    logic [31:0] mem_addr2;
    logic [31:0] mem_rd_data2 = '0;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic        stall2, done2, err2, halted2;

    int checks = 0;
    int errors = 0;
    bit rnd_ready = 1'b0;
    string cap = "";
    logic [31:0] rd_log[$];
    logic [31:0] mem [0:1023];

    bit   prev_v = 1'b0;
    bit   prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    always #5 clk = ~clk;

    syscall_unit u_dut (
        .clk(clk), .rst_n(rst_n), .syscall(syscall),
        .sys_call_reg(sys_call_reg), .std_out_address(std_out_address),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall(stall), .done(done), .err(err), .halted(halted)
    );

    syscall_unit #(.MAX_STR_LEN(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .syscall(syscall2),
        .sys_call_reg(code2), .std_out_address(arg2),
        .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rd_data(mem_rd_data2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(1'b1),
        .stall(stall2), .done(done2), .err(err2), .halted(halted2)
    );

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr[11:2]];
        if (mem_rd_en2) mem_rd_data2 <= mem[mem_addr2[11:2]];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r)
                chk(out_valid && out_data == prev_d, "hold",
                    $sformatf("v=%0b d=%h", out_valid, out_data),
                    $sformatf("v=1 d=%h", prev_d));
            if (out_valid && out_ready) cap = {cap, $sformatf("%c", out_data)};
            if (mem_rd_en) begin
                rd_log.push_back(mem_addr);
                chk(mem_addr[1:0] == 2'b00, "align", $sformatf("%h", mem_addr), "aligned");
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
        end
    end

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return 8'(w >> (8 * (3 - int'(a[1:0]))));
    endfunction

    task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
        int sh;
        sh = 8 * (3 - int'(a[1:0]));
        mem[a[11:2]] = (mem[a[11:2]] & ~(32'hff << sh)) | ({24'd0, b} << sh);
    endtask

    function automatic string model(input logic [31:0] code, input logic [31:0] arg,
                                    input int maxlen, output bit e);
        string s;
        logic [31:0] p;
        logic [7:0] b;
        s = "";
        e = 1'b0;
        p = arg;
        case (code)
            32'd1: s = $sformatf("%0d", $signed(arg));
            32'd4: begin
                for (int n = 0; n < maxlen; n++) begin
                    b = get_byte(p);
                    if (b == 8'h00) break;
                    s = {s, $sformatf("%c", b)};
                    p = p + 32'd1;
                end
            end
            32'd10: s = "";
            32'd11: s = $sformatf("%c", arg[7:0]);
`ifdef SYSCALL_HEX_EN
            32'd34: s = $sformatf("%08x", arg);
`endif
            default: e = 1'b1;
        endcase
        return s;
    endfunction

    task automatic check_zero(input string name);
        chk({stall, done, err, halted, out_valid, out_data, mem_rd_en, mem_addr} == '0,
            name, $sformatf("st=%0b dn=%0b er=%0b h=%0b v=%0b d=%h rd=%0b a=%h",
            stall, done, err, halted, out_valid, out_data, mem_rd_en, mem_addr),
            "all zero");
    endtask

    task automatic do_call(input logic [31:0] code, input logic [31:0] arg,
                           input bit rnd, input string exp, input bit exp_err,
                           input int exp_lat, input string name);
        int lat;
        bit got, got_err, stall_ok;
        cap = "";
        rd_log.delete();
        rnd_ready = rnd;
        @(posedge clk);
        #1;
        sys_call_reg = code;
        std_out_address = arg;
        syscall = 1'b1;
        @(negedge clk);
        chk(stall, {name, " accept stall"}, $sformatf("%0b", stall), "1");
        lat = 0;
        got = 0;
        got_err = 0;
        stall_ok = 1;
        while (!got && lat < 3000) begin
            @(posedge clk);
            #1;
            syscall = 1'b0;
            sys_call_reg = $urandom;
            std_out_address = $urandom;
            lat++;
            @(negedge clk);
            if (!stall) stall_ok = 0;
            if (done) begin
                got = 1;
                got_err = err;
            end
        end
        rnd_ready = 1'b0;
        chk(got, {name, " done"}, "timeout", "done pulse");
        if (!got) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            chk(cap == exp, {name, " bytes"}, {"\"", cap, "\""}, {"\"", exp, "\""});
            chk(got_err == exp_err, {name, " err"}, $sformatf("%0b", got_err),
                $sformatf("%0b", exp_err));
            chk(stall_ok, {name, " stall"}, "dropped", "held to done");
            if (exp_lat >= 0)
                chk(lat == exp_lat, {name, " latency"}, $sformatf("%0d", lat),
                    $sformatf("%0d", exp_lat));
        end
    endtask

    typedef struct {
        logic [31:0] code;
        logic [31:0] arg;
        bit          rnd;
        string       exp;
        bit          exp_err;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        string exp, cap2;
        bit e, bad, got2;
        logic [31:0] code, arg, base;
        int len, kind;
        logic [31:0] bad_codes[8];

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0] = 32'h0000_4869;
        mem[1] = 32'h2100_abcd;

        tbl.push_back('{32'd11, 32'h41, 1'b0, "A", 1'b0, 3});
        tbl.push_back('{32'd1, 32'hffff_ff85, 1'b0, "-123", 1'b0, -1});
        tbl.push_back('{32'd1, 32'h0, 1'b0, "0", 1'b0, -1});
        tbl.push_back('{32'd1, 32'h8000_0000, 1'b0, "-2147483648", 1'b0, -1});
        tbl.push_back('{32'd1, 32'd4095, 1'b1, "4095", 1'b0, -1});
        tbl.push_back('{32'd4, 32'h1002, 1'b0, "Hi!", 1'b0, -1});
        tbl.push_back('{32'd4, 32'h1002, 1'b1, "Hi!", 1'b0, -1});
        tbl.push_back('{32'd7, 32'h0, 1'b0, "", 1'b1, 2});
`ifdef SYSCALL_HEX_EN
        tbl.push_back('{32'd34, 32'hdead_beef, 1'b1, "deadbeef", 1'b0, -1});
`else
        tbl.push_back('{32'd34, 32'hdead_beef, 1'b0, "", 1'b1, 2});
`endif

        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        foreach (tbl[i]) begin
            do_call(tbl[i].code, tbl[i].arg, tbl[i].rnd, tbl[i].exp,
                    tbl[i].exp_err, tbl[i].lat, $sformatf("vec%0d", i));
            if (tbl[i].code == 32'd4)
                chk(rd_log.size() == 2 && rd_log[0] == 32'h1000 && rd_log[1] == 32'h1004,
                    $sformatf("vec%0d reads", i), $sformatf("%p", rd_log),
                    "'{0x1000,0x1004}");
        end

        cap2 = "";
        got2 = 0;
        @(posedge clk);
        #1;
        code2 = 32'd4;
        arg2 = 32'h1002;
        syscall2 = 1'b1;
        @(posedge clk);
        #1;
        syscall2 = 1'b0;
        for (int c = 0; c < 100 && !got2; c++) begin
            @(negedge clk);
            if (out_valid2) cap2 = {cap2, $sformatf("%c", out_data2)};
            if (done2) got2 = 1;
        end
        chk(got2, "maxlen done", "timeout", "done pulse");
        chk(cap2 == "Hi", "maxlen bytes", cap2, "Hi");

        do_call(32'd10, 32'h0, 1'b0, "", 1'b0, 2, "exit");
        chk(halted, "halted set", $sformatf("%0b", halted), "1");
        @(posedge clk);
        #1;
        sys_call_reg = 32'd11;
        std_out_address = 32'h42;
        syscall = 1'b1;
        @(negedge clk);
        chk(!stall, "halted stall", $sformatf("%0b", stall), "0");
        @(posedge clk);
        #1;
        syscall = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (stall || out_valid || done) bad = 1;
        end
        chk(!bad && halted, "halted ignore", $sformatf("act=%0b h=%0b", bad, halted),
            "act=0 h=1");

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sys_call_reg = 32'd4;
        std_out_address = 32'h1002;
        syscall = 1'b1;
        @(posedge clk);
        #1;
        syscall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid reset");
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_call(32'd11, 32'h5a, 1'b0, "Z", 1'b0, 3, "after reset");

        bad_codes = '{32'd0, 32'd2, 32'd3, 32'd5, 32'd12, 32'd99, 32'd35, 32'hffff_ffff};
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            arg = $urandom;
            case (kind)
                0: code = 32'd1;
                1: begin
                    code = 32'd4;
                    base = 32'h200 + $urandom_range(0, 32'hc00);
                    len = $urandom_range(0, 12);
                    for (int k = 0; k < len; k++)
                        set_byte(base + k, 8'($urandom_range(33, 126)));
                    set_byte(base + len, 8'h00);
                    arg = base;
                end
                2: begin
                    code = 32'd11;
                    arg[7:0] = 8'($urandom_range(33, 126));
                end
                3: code = bad_codes[$urandom_range(0, 7)];
                4: code = 32'd34;
                default: begin
                    code = 32'd1;
                    arg = 32'($signed(16'($urandom)));
                end
            endcase
            exp = model(code, arg, 256, e);
            do_call(code, arg, 1'($urandom_range(0, 1)), exp, e, -1,
                    $sformatf("rnd%0d c=%0d a=%h", it, code, arg));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
